// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared widths, constants and pin-mask type for the PWM output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int              NUM_OUT         = 16;
  localparam int              PWM_W           = 8;
  localparam logic [PWM_W-1:0] PWM_FULL       = 8'hFF;
  localparam int              CLK_DIV_DEFAULT = 13;

  typedef logic [NUM_OUT-1:0] pin_mask_t;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
// Module   : pwm_timebase
// Purpose  : Prescaler plus 8-bit PWM counter; strobes wrap on the 255->0 step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [PWM_W-1:0] pwm_cnt_o,
  output logic             wrap_o
);

  // A one-bit prescaler that never leaves zero keeps CLK_DIV=1 legal.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             w_tick;

  always_comb begin
    w_tick    = (div_cnt_q == DIV_LAST);
    div_cnt_d = w_tick ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d = w_tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt_o = pwm_cnt_q;
  assign wrap_o    = w_tick && (pwm_cnt_q == PWM_FULL);

endmodule : pwm_timebase

`default_nettype wire

// File: rtl/pwm_peripheral.sv
// ============================================================================
// Module   : pwm_peripheral
// Purpose  : Drives 16 pins as static levels or a shared PWM with shadowed duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OUT-1:0] en_out,
  input  logic [NUM_OUT-1:0] en_pwm,
  input  logic [PWM_W-1:0]   duty,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic [PWM_W-1:0] w_pwm_cnt;
  logic             w_wrap;
  logic             w_pwm_level;
  logic [PWM_W-1:0] duty_q, duty_d;
  pin_mask_t        out_q, out_d;
  logic             wrap_dly_q;
  logic             period_start_q;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk_i     (clk),
    .rst_i     (rst),
    .pwm_cnt_o (w_pwm_cnt),
    .wrap_o    (w_wrap)
  );

  // Duty is sampled only on the wrap so every period runs with one value.
  always_comb begin
    duty_d      = w_wrap ? duty : duty_q;
    w_pwm_level = (duty_q == PWM_FULL) || (w_pwm_cnt < duty_q);
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_pin
    assign out_d[i] = en_out[i] & (~en_pwm[i] | w_pwm_level);
  end

  // period_start trails wrap by two clocks: one for the counter to reach 0,
  // one for out to register that count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q         <= '0;
      out_q          <= '0;
      wrap_dly_q     <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_q         <= duty_d;
      out_q          <= out_d;
      wrap_dly_q     <= w_wrap;
      period_start_q <= wrap_dly_q;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule : pwm_peripheral

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// ============================================================================
// Module   : tb_pwm_peripheral
// Purpose  : Self-checking bench for pwm_peripheral (CLK_DIV=13 and CLK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_peripheral;

  localparam int DIV    = 13;
  localparam int PERIOD = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out, en_pwm, out;
  logic [7:0]  duty;
  logic        period_start;
  logic [15:0] en_out1, en_pwm1, out1;
  logic [7:0]  duty1;
  logic        ps1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .out          (out),
    .period_start (period_start)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out1),
    .en_pwm       (en_pwm1),
    .duty         (duty1),
    .out          (out1),
    .period_start (ps1)
  );

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp_out;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Steps until period_start; hi counts out[0] highs on the cycles before it.
  task automatic wait_ps(input bit sel, input int budget, output int hi, output bit ok);
    hi = 0;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sel ? ps1 : period_start) begin
        ok = 1'b1;
        break;
      end
      hi += (sel ? out1[0] : out[0]) ? 1 : 0;
    end
  endtask

  // Starts on a period_start cycle, ends on the next one.
  task automatic measure(input bit sel, input int chg_at, input logic [7:0] chg_duty,
                         output int hi, output int len, output logic rise);
    int lim;
    lim  = (sel ? 256 : PERIOD) + 20;
    hi   = 0;
    len  = 0;
    rise = sel ? out1[0] : out[0];
    do begin
      hi += (sel ? out1[0] : out[0]) ? 1 : 0;
      len++;
      if (len == chg_at) duty = chg_duty;
      @(negedge clk);
    end while (!(sel ? ps1 : period_start) && len < lim);
  endtask

  // Writes a new duty at a period start: the current period keeps the old one.
  task automatic apply_duty(input string nm, input logic [7:0] d,
                            input int exp_prev, input int exp_hi);
    int   hi, len;
    logic rise;
    duty = d;
    exp_q.push_back(exp_prev);
    exp_q.push_back(exp_hi);
    exp_q.push_back(PERIOD);
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check({nm, "_old_period_hi"}, hi, exp_q.pop_front());
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check({nm, "_hi"}, hi, exp_q.pop_front());
    check({nm, "_len"}, len, exp_q.pop_front());
    if (exp_hi > 0) check({nm, "_rise_at_ps"}, rise, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   hi, len, nz;
    bit   ok;
    logic rise;

    vecs[0] = '{16'h00FF, 16'h0000, 8'd0, 16'h00FF};
    vecs[1] = '{16'hFF00, 16'h0000, 8'd0, 16'hFF00};
    vecs[2] = '{16'hFFFF, 16'h00F0, 8'd0, 16'hFF0F};
    vecs[3] = '{16'h0000, 16'hFFFF, 8'd0, 16'h0000};
    vecs[4] = '{16'hA5A5, 16'h0000, 8'd0, 16'hA5A5};

    rst     = 1'b1;
    en_out1 = 16'h0001;
    en_pwm1 = 16'h0001;
    duty1   = 8'd10;
    for (int k = 0; k < 4; k++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      duty   = 8'($urandom);
      @(negedge clk);
      check("reset_out", out, 0);
      check("reset_period_start", period_start, 0);
    end

    en_out = '0;
    en_pwm = '0;
    duty   = '0;
    rst    = 1'b0;
    nz     = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      nz += (out != 16'h0000) ? 1 : 0;
    end
    check("idle_out_nonzero_cycles", nz, 0);

    for (int v = 0; v < 5; v++) begin
      en_out = vecs[v].en_out;
      en_pwm = vecs[v].en_pwm;
      duty   = vecs[v].duty;
      exp_q.push_back(vecs[v].exp_out);
      @(negedge clk);
      check($sformatf("static_vec%0d", v), out, exp_q.pop_front());
    end

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    wait_ps(1'b0, PERIOD + 20, hi, ok);
    check("sync_period_start_seen", ok, 1);

    apply_duty("duty128", 8'd128, 0,    1664);
    apply_duty("duty0",   8'd0,   1664, 0);
    apply_duty("duty255", 8'd255, 0,    PERIOD);
    apply_duty("duty1",   8'd1,   PERIOD, 13);

    // Mid-period change 64 -> 192 around pwm_cnt=100.
    duty = 8'd64;
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check("midchg_pre_hi", hi, 13);
    exp_q.push_back(832);
    exp_q.push_back(2496);
    measure(1'b0, 100 * DIV, 8'd192, hi, len, rise);
    check("midchg_cur_hi", hi, exp_q.pop_front());
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check("midchg_next_hi", hi, exp_q.pop_front());

    // Reset pulse at pwm_cnt=50 with duty 200 active.
    duty = 8'd200;
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check("rst_pre_hi", hi, 2496);
    repeat (50 * DIV) @(negedge clk);
    check("rst_pre_out0", out[0], 1);
    rst = 1'b1;
    #1;
    check("rst_async_out", out, 0);
    check("rst_async_ps", period_start, 0);
    repeat (2) @(negedge clk);
    check("rst_held_out", out, 0);
    rst = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(2600);
    exp_q.push_back(PERIOD);
    wait_ps(1'b0, PERIOD + 20, hi, ok);
    check("rst_first_ps_seen", ok, 1);
    check("rst_first_period_hi", hi, exp_q.pop_front());
    measure(1'b0, 0, 8'd0, hi, len, rise);
    check("rst_second_period_hi", hi, exp_q.pop_front());
    check("rst_second_period_len", len, exp_q.pop_front());

    // CLK_DIV=1 instance, duty 10.
    wait_ps(1'b1, 300, hi, ok);
    check("div1_ps_seen", ok, 1);
    measure(1'b1, 0, 8'd0, hi, len, rise);
    check("div1_hi", hi, 10);
    check("div1_len", len, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_peripheral

`default_nettype wire
